adaptive_lane_scheduler: RTL

Parametrised N-lane adaptive traffic-light scheduler: serves lanes round-robin, skipping lanes with no demand, and times each phase with a tick-driven counter. Congestion sensors extend green a bounded number of times per service. It sits between the lane sensor front-end and the lamp driver, and succeeds the fixed 4-lane, one-cycle-per-phase controller.

---
 rtl/traffic_pkg.sv | 22 ++
 rtl/rr_lane_picker.sv | 38 +++
 rtl/adaptive_lane_scheduler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared phase encoding, default tick constants and lane-index width helper
// for the adaptive lane scheduler.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_SCAN   = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10,
    PH_ALLRED = 2'b11
  } phase_t;

  localparam int DEF_GREEN_TICKS  = 20;
  localparam int DEF_EXT_TICKS    = 10;
  localparam int DEF_MAX_EXT      = 1;
  localparam int DEF_YELLOW_TICKS = 4;
  localparam int DEF_ALLRED_TICKS = 2;

  function automatic int lane_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_lane_picker.sv
// Combinational rotating-priority select: first requesting lane at or above
// ptr, wrapping modulo NUM_LANES.
module rr_lane_picker
  import traffic_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = lane_idx_w(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [LANE_W-1:0]    ptr,
  output logic                 found,
  output logic [LANE_W-1:0]    idx
);

  logic [2*NUM_LANES-1:0] dbl;
  logic [NUM_LANES-1:0]   rot;

  // Duplicating the request vector turns the wrap-around into a plain slice.
  assign dbl = {req, req};
  assign rot = dbl[ptr +: NUM_LANES];

  always_comb begin
    int k;
    int s;
    found = 1'b0;
    k     = 0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        k     = i;
      end
    end
    s = int'(ptr) + k;
    if (s >= NUM_LANES) s = s - NUM_LANES;
    idx = LANE_W'(s);
  end

endmodule

// File: rtl/adaptive_lane_scheduler.sv
// N-lane round-robin traffic-light scheduler with tick-timed phases and
// bounded congestion extensions. Optional preemption: EMERGENCY_PREEMPT_EN.
module adaptive_lane_scheduler
  import traffic_pkg::*;
#(
  parameter int NUM_LANES    = 4,
  parameter int LANE_W       = lane_idx_w(NUM_LANES),
  parameter int TIMER_W      = 8,
  parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter int EXT_TICKS    = DEF_EXT_TICKS,
  parameter int MAX_EXT      = DEF_MAX_EXT,
  parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter int ALLRED_TICKS = DEF_ALLRED_TICKS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic [NUM_LANES-1:0] start_sensor,
  input  logic [NUM_LANES-1:0] congest_sensor,
  output logic [NUM_LANES-1:0] green,
  output logic [NUM_LANES-1:0] yellow,
  output logic [1:0]           phase,
  output logic [LANE_W-1:0]    active_lane,
  output logic                 ext_active,
  output logic                 lane_served
`ifdef EMERGENCY_PREEMPT_EN
  ,
  input  logic                 preempt_req,
  input  logic [LANE_W-1:0]    preempt_lane,
  output logic                 preempt_active
`endif
);

  phase_t                 state_reg, state_next;
  logic [LANE_W-1:0]      ptr_reg, ptr_next;
  logic [LANE_W-1:0]      active_reg, active_next;
  logic [TIMER_W-1:0]     timer_reg, timer_next;
  logic [3:0]             ext_cnt_reg, ext_cnt_next;
  logic                   ext_reg, ext_next;
  logic                   served_reg, served_next;
  logic [NUM_LANES-1:0]   green_reg, green_next;
  logic [NUM_LANES-1:0]   yellow_reg, yellow_next;
  logic                   found;
  logic [LANE_W-1:0]      pick_idx;
  logic                   expire;

  rr_lane_picker #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W)
  ) u_picker (
    .req   (start_sensor),
    .ptr   (ptr_reg),
    .found (found),
    .idx   (pick_idx)
  );

  // Timer <= 1 also covers a stray zero so a phase can never stall.
  assign expire = tick && (timer_reg <= TIMER_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= PH_SCAN;
      ptr_reg     <= '0;
      active_reg  <= '0;
      timer_reg   <= '0;
      ext_cnt_reg <= '0;
      ext_reg     <= 1'b0;
      served_reg  <= 1'b0;
      green_reg   <= '0;
      yellow_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      active_reg  <= active_next;
      timer_reg   <= timer_next;
      ext_cnt_reg <= ext_cnt_next;
      ext_reg     <= ext_next;
      served_reg  <= served_next;
      green_reg   <= green_next;
      yellow_reg  <= yellow_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    active_next  = active_reg;
    timer_next   = timer_reg;
    ext_cnt_next = ext_cnt_reg;
    ext_next     = ext_reg;
    served_next  = 1'b0;
    case (state_reg)
      PH_SCAN: begin
`ifdef EMERGENCY_PREEMPT_EN
        if (preempt_req) begin
          active_next  = preempt_lane;
          timer_next   = TIMER_W'(GREEN_TICKS);
          ext_cnt_next = '0;
          ext_next     = 1'b0;
          state_next   = PH_GREEN;
        end else
`endif
        if (found) begin
          active_next  = pick_idx;
          timer_next   = TIMER_W'(GREEN_TICKS);
          ext_cnt_next = '0;
          ext_next     = 1'b0;
          state_next   = PH_GREEN;
        end
      end
      PH_GREEN: begin
`ifdef EMERGENCY_PREEMPT_EN
        if (preempt_req && (active_reg != preempt_lane)) begin
          timer_next = TIMER_W'(YELLOW_TICKS);
          ext_next   = 1'b0;
          state_next = PH_YELLOW;
        end else if (preempt_req) begin
          timer_next = timer_reg;
        end else
`endif
        if (expire) begin
          if (congest_sensor[active_reg] && (ext_cnt_reg < 4'(MAX_EXT))) begin
            timer_next   = TIMER_W'(EXT_TICKS);
            ext_cnt_next = ext_cnt_reg + 4'd1;
            ext_next     = 1'b1;
          end else begin
            timer_next = TIMER_W'(YELLOW_TICKS);
            ext_next   = 1'b0;
            state_next = PH_YELLOW;
          end
        end else if (tick) begin
          timer_next = timer_reg - TIMER_W'(1);
        end
      end
      PH_YELLOW: begin
        if (expire) begin
          timer_next = TIMER_W'(ALLRED_TICKS);
          state_next = PH_ALLRED;
        end else if (tick) begin
          timer_next = timer_reg - TIMER_W'(1);
        end
      end
      PH_ALLRED: begin
        if (expire) begin
          timer_next  = '0;
          state_next  = PH_SCAN;
          served_next = 1'b1;
          ptr_next    = (active_reg == LANE_W'(NUM_LANES - 1)) ? '0
                                                                : active_reg + LANE_W'(1);
        end else if (tick) begin
          timer_next = timer_reg - TIMER_W'(1);
        end
      end
      default: begin
        state_next = PH_SCAN;
        timer_next = '0;
        ext_next   = 1'b0;
      end
    endcase
  end

  // Lamps are derived from the next state so they switch with phase.
  always_comb begin
    green_next  = '0;
    yellow_next = '0;
    if (state_next == PH_GREEN)  green_next[active_next]  = 1'b1;
    if (state_next == PH_YELLOW) yellow_next[active_next] = 1'b1;
  end

`ifdef EMERGENCY_PREEMPT_EN
  logic preempt_reg, preempt_next;

  // Outside GREEN the scheduler is always heading back to SCAN, which picks
  // preempt_lane while the request stays up.
  assign preempt_next = preempt_req &&
                        ((state_next != PH_GREEN) || (active_next == preempt_lane));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) preempt_reg <= 1'b0;
    else        preempt_reg <= preempt_next;
  end

  assign preempt_active = preempt_reg;
`endif

  assign green       = green_reg;
  assign yellow      = yellow_reg;
  assign phase       = state_reg;
  assign active_lane = active_reg;
  assign ext_active  = ext_reg;
  assign lane_served = served_reg;

endmodule
